// File: rtl/cmp_result_monitor_if.sv
// rtl/cmp_result_monitor_if.sv - operand/result stream bundle for cmp_result_monitor
//
// Purpose: groups the operand-pair input stream and the compare-result output
// stream of cmp_result_monitor into a single interface.
// Signals:
//   in_valid / in_ready      operand pair handshake
//   in_a / in_b              operands (WIDTH bits, unsigned)
//   out_valid / out_ready    result handshake
//   out_eq / out_gt / out_lt registered compare flags
// Modports:
//   master  operand source and result consumer (drives in_*, out_ready)
//   slave   the compare stage (drives in_ready, out_*)

interface cmp_result_monitor_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic             out_eq;
    logic             out_gt;
    logic             out_lt;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_eq, out_gt, out_lt
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_eq, out_gt, out_lt
    );
endinterface

// File: rtl/cmp_result_monitor.sv
// rtl/cmp_result_monitor.sv - streaming unsigned compare stage with outcome statistics
//
// Purpose: accepts operand pairs over a valid/ready handshake, presents
// registered eq/gt/lt flags one cycle later through a single-entry output
// register, keeps saturating per-outcome counters and raises a sticky alarm
// after RUN_THRESH consecutive accepted A>B results.
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of counters, run tracker and alarm
//   bus        cmp_result_monitor_if.slave (in_* / out_* streams)
//   cnt_eq     saturating count of accepted eq results
//   cnt_gt     saturating count of accepted gt results
//   cnt_lt     saturating count of accepted lt results
//   run_alarm  sticky alarm flag
//   stall_cnt  saturating count of stalled output cycles (CMP_STALL_CNT_EN only)
// Optional feature macro: CMP_STALL_CNT_EN

module cmp_result_monitor #(
    parameter int WIDTH      = 4,
    parameter int CNT_W      = 8,
    parameter int RUN_THRESH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    cmp_result_monitor_if.slave bus,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [CNT_W-1:0] cnt_gt,
    output logic [CNT_W-1:0] cnt_lt,
`ifdef CMP_STALL_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
`endif
    output logic             run_alarm
);

    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(RUN_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2
    } run_state_t;

    run_state_t       state;
    logic [CNT_W-1:0] run_cnt;

    logic             out_valid_q;
    logic             out_eq_q;
    logic             out_gt_q;
    logic             out_lt_q;

    logic             ready;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cmp_decided;
    logic             cmp_gt;
    logic             new_eq;
    logic             new_gt;
    logic             new_lt;

    assign op_a   = bus.in_a;
    assign op_b   = bus.in_b;

    // Single-entry pipeline: room exists when empty or when the held result
    // is leaving this cycle.
    assign ready  = !out_valid_q || bus.out_ready;
    assign accept = bus.in_valid && ready;

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_eq    = out_eq_q;
    assign bus.out_gt    = out_gt_q;
    assign bus.out_lt    = out_lt_q;

    // MSB-first priority compare: the first differing bit from the top decides.
    always_comb begin
        cmp_decided = 1'b0;
        cmp_gt      = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!cmp_decided && (op_a[i] != op_b[i])) begin
                cmp_decided = 1'b1;
                cmp_gt      = op_a[i];
            end
        end
    end

    assign new_eq = !cmp_decided;
    assign new_gt = cmp_decided && cmp_gt;
    assign new_lt = cmp_decided && !cmp_gt;

    // Result register: flags only change on accept, so a consume without a
    // new accept clears valid but leaves the last flags visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_eq_q    <= 1'b0;
            out_gt_q    <= 1'b0;
            out_lt_q    <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_eq_q    <= new_eq;
            out_gt_q    <= new_gt;
            out_lt_q    <= new_lt;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Outcome statistics; clr takes priority over a same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_eq <= '0;
            cnt_gt <= '0;
            cnt_lt <= '0;
        end else if (clr) begin
            cnt_eq <= '0;
            cnt_gt <= '0;
            cnt_lt <= '0;
        end else if (accept) begin
            if (new_eq && cnt_eq != CNT_MAX) cnt_eq <= cnt_eq + 1'b1;
            if (new_gt && cnt_gt != CNT_MAX) cnt_gt <= cnt_gt + 1'b1;
            if (new_lt && cnt_lt != CNT_MAX) cnt_lt <= cnt_lt + 1'b1;
        end
    end

    // Run tracker: counts consecutive accepted gt results; ALARM is terminal
    // until clr or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            run_cnt   <= '0;
            run_alarm <= 1'b0;
        end else if (clr) begin
            state     <= ST_IDLE;
            run_cnt   <= '0;
            run_alarm <= 1'b0;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (new_gt) begin
                        run_cnt <= CNT_W'(1);
                        if (THRESH == CNT_W'(1)) begin
                            state     <= ST_ALARM;
                            run_alarm <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (new_gt) begin
                        run_cnt <= run_cnt + 1'b1;
                        if ((run_cnt + 1'b1) == THRESH) begin
                            state     <= ST_ALARM;
                            run_alarm <= 1'b1;
                        end
                    end else begin
                        state   <= ST_IDLE;
                        run_cnt <= '0;
                    end
                end
                ST_ALARM: begin
                    run_alarm <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    run_cnt   <= '0;
                    run_alarm <= 1'b0;
                end
            endcase
        end
    end

`ifdef CMP_STALL_CNT_EN
    // Counts cycles where a result is held back by the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (clr) begin
            stall_cnt <= '0;
        end else if (out_valid_q && !bus.out_ready && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cmp_result_monitor.sv
// tb/tb_cmp_result_monitor.sv - directed self-checking bench for cmp_result_monitor

module tb_cmp_result_monitor;

    logic clk;
    logic rst_n;
    logic clr_a;
    logic clr_b;

    logic [7:0] cnt_eq_a, cnt_gt_a, cnt_lt_a;
    logic       run_alarm_a;
    logic [1:0] cnt_eq_b, cnt_gt_b, cnt_lt_b;
    logic       run_alarm_b;
`ifdef CMP_STALL_CNT_EN
    logic [7:0] stall_cnt_a;
    logic [1:0] stall_cnt_b;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    cmp_result_monitor_if #(.WIDTH(4)) ifa ();
    cmp_result_monitor_if #(.WIDTH(4)) ifb ();

    cmp_result_monitor #(.WIDTH(4), .CNT_W(8), .RUN_THRESH(3)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_a),
        .bus       (ifa),
        .cnt_eq    (cnt_eq_a),
        .cnt_gt    (cnt_gt_a),
        .cnt_lt    (cnt_lt_a),
`ifdef CMP_STALL_CNT_EN
        .stall_cnt (stall_cnt_a),
`endif
        .run_alarm (run_alarm_a)
    );

    cmp_result_monitor #(.WIDTH(4), .CNT_W(2), .RUN_THRESH(3)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_b),
        .bus       (ifb),
        .cnt_eq    (cnt_eq_b),
        .cnt_gt    (cnt_gt_b),
        .cnt_lt    (cnt_lt_b),
`ifdef CMP_STALL_CNT_EN
        .stall_cnt (stall_cnt_b),
`endif
        .run_alarm (run_alarm_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic set_a(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic ordy, input logic c);
        ifa.in_valid  = v;
        ifa.in_a      = a;
        ifa.in_b      = b;
        ifa.out_ready = ordy;
        clr_a         = c;
        #1;
    endtask

    task automatic set_b(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic ordy, input logic c);
        ifb.in_valid  = v;
        ifb.in_a      = a;
        ifb.in_b      = b;
        ifb.out_ready = ordy;
        clr_b         = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flags_a(input string tag, input logic eq, input logic gt, input logic lt);
        check({tag, "_eq"}, 32'(ifa.out_eq), 32'(eq));
        check({tag, "_gt"}, 32'(ifa.out_gt), 32'(gt));
        check({tag, "_lt"}, 32'(ifa.out_lt), 32'(lt));
    endtask

    task automatic cnts_a(input string tag, input int e, input int g, input int l);
        check({tag, "_cnt_eq"}, 32'(cnt_eq_a), 32'(e));
        check({tag, "_cnt_gt"}, 32'(cnt_gt_a), 32'(g));
        check({tag, "_cnt_lt"}, 32'(cnt_lt_a), 32'(l));
    endtask

    initial begin
        rst_n = 1'b0;
        set_a(0, 4'd0, 4'd0, 0, 0);
        set_b(0, 4'd0, 4'd0, 0, 0);
        tick();
        tick();
        check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
        flags_a("rst", 0, 0, 0);
        cnts_a("rst", 0, 0, 0);
        check("rst_alarm", 32'(run_alarm_a), 32'd0);
        check("rst_in_ready", 32'(ifa.in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // single pair 1010 vs 1001
        set_a(1, 4'b1010, 4'b1001, 1, 0);
        check("t1_in_ready", 32'(ifa.in_ready), 32'd1);
        tick();
        check("t1_out_valid", 32'(ifa.out_valid), 32'd1);
        flags_a("t1", 0, 1, 0);
        cnts_a("t1", 0, 1, 0);

        // clear, then back-to-back eq/lt/gt
        set_a(0, 4'd0, 4'd0, 1, 1);
        tick();
        check("clr_out_valid", 32'(ifa.out_valid), 32'd0);
        check("clr_flag_hold", 32'(ifa.out_gt), 32'd1);
        cnts_a("clr", 0, 0, 0);
        set_a(1, 4'd3, 4'd3, 1, 0);
        tick();
        flags_a("b2b0", 1, 0, 0);
        check("b2b0_in_ready", 32'(ifa.in_ready), 32'd1);
        set_a(1, 4'd2, 4'd7, 1, 0);
        tick();
        flags_a("b2b1", 0, 0, 1);
        check("b2b1_in_ready", 32'(ifa.in_ready), 32'd1);
        set_a(1, 4'd9, 4'd4, 1, 0);
        tick();
        flags_a("b2b2", 0, 1, 0);
        check("b2b2_out_valid", 32'(ifa.out_valid), 32'd1);
        cnts_a("b2b", 1, 1, 1);

        // backpressure: hold out_ready low for 4 cycles
        set_a(1, 4'd0, 4'd5, 0, 0);
        check("stall_in_ready0", 32'(ifa.in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_out_valid", 32'(ifa.out_valid), 32'd1);
            check("stall_gt", 32'(ifa.out_gt), 32'd1);
            check("stall_in_ready", 32'(ifa.in_ready), 32'd0);
            check("stall_cnt_lt", 32'(cnt_lt_a), 32'd1);
        end
`ifdef CMP_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt_a), 32'd4);
`endif
        set_a(1, 4'd0, 4'd5, 1, 0);
        tick();
        flags_a("unstall", 0, 0, 1);
        check("unstall_cnt_lt", 32'(cnt_lt_a), 32'd2);
        set_a(0, 4'd0, 4'd0, 1, 0);
        tick();
        check("drain_out_valid", 32'(ifa.out_valid), 32'd0);
        check("drain_lt_hold", 32'(ifa.out_lt), 32'd1);

        // run alarm after three gt, sticky through eq, cleared by clr
        set_a(0, 4'd0, 4'd0, 1, 1);
        tick();
        set_a(1, 4'd5, 4'd1, 1, 0);
        tick();
        set_a(1, 4'd6, 4'd2, 1, 0);
        tick();
        check("run2_alarm", 32'(run_alarm_a), 32'd0);
        set_a(1, 4'd7, 4'd3, 1, 0);
        tick();
        check("run3_alarm", 32'(run_alarm_a), 32'd1);
        set_a(1, 4'd1, 4'd1, 1, 0);
        tick();
        check("sticky_alarm", 32'(run_alarm_a), 32'd1);
        cnts_a("alarm", 1, 3, 0);
        set_a(0, 4'd0, 4'd0, 1, 1);
        tick();
        check("clr_alarm", 32'(run_alarm_a), 32'd0);
        cnts_a("clr2", 0, 0, 0);

        // gt gt lt gt: lt breaks the run
        set_a(1, 4'd9, 4'd1, 1, 0);
        tick();
        set_a(1, 4'd9, 4'd2, 1, 0);
        tick();
        set_a(1, 4'd1, 4'd9, 1, 0);
        tick();
        check("broken_lt_alarm", 32'(run_alarm_a), 32'd0);
        set_a(1, 4'd9, 4'd3, 1, 0);
        tick();
        check("broken_alarm", 32'(run_alarm_a), 32'd0);

        // clr with a same-cycle gt accept: result presented, not counted
        set_a(0, 4'd0, 4'd0, 1, 1);
        tick();
        set_a(1, 4'd8, 4'd2, 1, 1);
        tick();
        check("clracc_out_valid", 32'(ifa.out_valid), 32'd1);
        check("clracc_gt", 32'(ifa.out_gt), 32'd1);
        check("clracc_cnt_gt", 32'(cnt_gt_a), 32'd0);
        set_a(1, 4'd8, 4'd3, 1, 0);
        tick();
        set_a(1, 4'd8, 4'd4, 1, 0);
        tick();
        check("clracc_run2_alarm", 32'(run_alarm_a), 32'd0);
        set_a(1, 4'd8, 4'd5, 1, 0);
        tick();
        check("clracc_run3_alarm", 32'(run_alarm_a), 32'd1);
        check("clracc_cnt_gt3", 32'(cnt_gt_a), 32'd3);
        set_a(0, 4'd0, 4'd0, 1, 0);

        // CNT_W=2 instance: eq counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            set_b(1, 4'(i), 4'(i), 1, 0);
            tick();
            check("sat_eq_flag", 32'(ifb.out_eq), 32'd1);
            check("sat_cnt_eq", 32'(cnt_eq_b), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        set_b(1, 4'd12, 4'd3, 1, 1);
        tick();
        check("b_clracc_gt", 32'(ifb.out_gt), 32'd1);
        check("b_clracc_cnt_gt", 32'(cnt_gt_b), 32'd0);
        check("b_clracc_cnt_eq", 32'(cnt_eq_b), 32'd0);
        set_b(0, 4'd0, 4'd0, 1, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
